// File: rtl/fifo_frame_reader.sv
// ============================================================================
// fifo_frame_reader
// ----------------------------------------------------------------------------
// Consumer end of the audio byte FIFO. Pops payload bytes one at a time
// (the FIFO has a one-cycle read latency) and wraps them into fixed-size
// frames that are streamed byte-wise over a valid/ready link to the optical
// transmitter:
//
//     SYNC_BYTE, seq, payload[0 .. PAYLOAD_BYTES-1] [, checksum]
//
// Build option:
//   FRAMER_CHECKSUM_EN  defined   -> a checksum byte closes every frame
//                                    (8-bit sum of seq and all payload bytes).
//                       undefined -> no checksum byte; the frame ends on the
//                                    last payload byte.
//
// Parameters:
//   PAYLOAD_BYTES  payload bytes per frame, 1..255
//   SYNC_BYTE      first byte of every frame
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   rst          in   synchronous, active-high reset
//   empty        in   FIFO empty flag
//   fifo_dout    in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   out  FIFO pop strobe, one cycle per byte
//   tx_ready     in   transmitter accepts tx_data this cycle
//   tx_valid     out  tx_data valid
//   tx_data      out  frame byte to the transmitter
//   frame_ready  out  framer is idle and can start a new frame
//   frame_done   out  one-cycle pulse on the handshake of the last frame byte
// ============================================================================
module fifo_frame_reader #(
    parameter int unsigned PAYLOAD_BYTES = 16,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd_en,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       frame_ready,
    output logic       frame_done
);

    // Index of the last payload byte within a frame.
    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,   // waiting for the FIFO to hold data
        S_SYNC,   // presenting SYNC_BYTE
        S_SEQ,    // presenting the sequence number
        S_FETCH,  // popping the next payload byte
        S_WAIT,   // FIFO read latency; capture the popped byte
        S_DATA    // presenting a payload byte
`ifdef FRAMER_CHECKSUM_EN
        ,
        S_CKSUM   // presenting the checksum byte
`endif
    } state_t;

    state_t     state_q,    state_d;
    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q,  tx_data_d;
    logic [7:0] seq_q,      seq_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
`ifdef FRAMER_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;
`endif

    // A byte moves to the transmitter only on a completed handshake.
    logic handshake;
    assign handshake = tx_valid_q && tx_ready;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its _d input, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            seq_q      <= 8'h00;
            byte_cnt_q <= 8'h00;
`ifdef FRAMER_CHECKSUM_EN
            checksum_q <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            seq_q      <= seq_d;
            byte_cnt_q <= byte_cnt_d;
`ifdef FRAMER_CHECKSUM_EN
            checksum_q <= checksum_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would otherwise infer a latch.
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        seq_d      = seq_q;
        byte_cnt_d = byte_cnt_q;
`ifdef FRAMER_CHECKSUM_EN
        checksum_d = checksum_q;
`endif
        fifo_rd_en = 1'b0;
        frame_done = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Only start a frame once at least one payload byte exists,
                // so a frame header is never sent for an empty FIFO.
                if (!empty) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = SYNC_BYTE;
`ifdef FRAMER_CHECKSUM_EN
                    checksum_d = 8'h00;
`endif
                    state_d    = S_SYNC;
                end
            end

            S_SYNC: begin
                if (handshake) begin
                    tx_data_d = seq_q;
                    state_d   = S_SEQ;
                end
            end

            S_SEQ: begin
                if (handshake) begin
                    tx_valid_d = 1'b0;
                    byte_cnt_d = 8'h00;
`ifdef FRAMER_CHECKSUM_EN
                    checksum_d = seq_q;
`endif
                    state_d    = S_FETCH;
                end
            end

            S_FETCH: begin
                // Output is idle here, so a pop never overtakes a pending byte.
                // An empty FIFO simply stalls the frame.
                if (!empty && !rst) begin
                    fifo_rd_en = 1'b1;
                    state_d    = S_WAIT;
                end
            end

            S_WAIT: begin
                tx_valid_d = 1'b1;
                tx_data_d  = fifo_dout;
`ifdef FRAMER_CHECKSUM_EN
                checksum_d = checksum_q + fifo_dout;
`endif
                state_d    = S_DATA;
            end

            S_DATA: begin
                if (handshake) begin
                    tx_valid_d = 1'b0;
                    if (byte_cnt_q == LAST_IDX) begin
`ifdef FRAMER_CHECKSUM_EN
                        // checksum_q already includes the byte just sent.
                        tx_valid_d = 1'b1;
                        tx_data_d  = checksum_q;
                        state_d    = S_CKSUM;
`else
                        frame_done = !rst;
                        seq_d      = seq_q + 8'd1;
                        state_d    = S_IDLE;
`endif
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        state_d    = S_FETCH;
                    end
                end
            end

`ifdef FRAMER_CHECKSUM_EN
            S_CKSUM: begin
                if (handshake) begin
                    tx_valid_d = 1'b0;
                    frame_done = !rst;
                    seq_d      = seq_q + 8'd1;
                    state_d    = S_IDLE;
                end
            end
`endif

            default: begin
                tx_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign frame_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_fifo_frame_reader.sv
module tb_fifo_frame_reader;

    localparam int         PB   = 16;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef FRAMER_CHECKSUM_EN
    localparam int FL = PB + 3;
`else
    localparam int FL = PB + 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       frame_ready;
    logic       frame_done;

    always #5 clk = ~clk;

    fifo_frame_reader #(.PAYLOAD_BYTES(PB), .SYNC_BYTE(SYNC)) dut (
        .clk         (clk),
        .rst         (rst),
        .empty       (empty),
        .fifo_dout   (fifo_dout),
        .fifo_rd_en  (fifo_rd_en),
        .tx_ready    (tx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .frame_ready (frame_ready),
        .frame_done  (frame_done)
    );

    // ------------------------------------------------------------------
    // FIFO model: one-cycle read latency
    // ------------------------------------------------------------------
    logic [7:0] mem [0:8191];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       hold_empty = 1'b0;

    assign empty = hold_empty || (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr & 8191];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr & 8191] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // ------------------------------------------------------------------
    // Transmitter-side monitor: collects bytes and protocol violations
    // ------------------------------------------------------------------
    logic [7:0] rx_q[$];
    int         done_q[$];
    int         viol = 0;
    logic       prev_rd = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            prev_rd    <= 1'b0;
            prev_stall <= 1'b0;
        end else begin
            if (fifo_rd_en && (empty || prev_rd || tx_valid))
                viol <= viol + 1;
            else if (prev_stall && !(tx_valid && tx_data == prev_data))
                viol <= viol + 1;
            else if (frame_done && !(tx_valid && tx_ready))
                viol <= viol + 1;
            if (tx_valid && tx_ready) begin
                rx_q.push_back(tx_data);
                if (frame_done) done_q.push_back(rx_q.size());
            end
            prev_rd    <= fifo_rd_en;
            prev_stall <= tx_valid && !tx_ready;
            prev_data  <= tx_data;
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_rx(input int need, input int budget, input string name);
        int k = 0;
        while (rx_q.size() < need && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, 32'(rx_q.size() >= need), 1);
    endtask

    // Compares one received frame against a frame built here from seq and
    // an arithmetic payload pattern first, first+step, ...
    task automatic compare_frame(input string name, input int start, input logic [7:0] seq,
                                 input logic [7:0] first, input logic [7:0] step);
        logic [7:0] exp_b;
        logic [7:0] sum;
        int         found;
        if (rx_q.size() < start + FL) begin
            check({name, "_len"}, rx_q.size(), start + FL);
            return;
        end
        sum = seq;
        check({name, "_sync"}, rx_q[start], SYNC);
        check({name, "_seq"}, rx_q[start+1], seq);
        for (int i = 0; i < PB; i++) begin
            exp_b = first + 8'(int'(step) * i);
            sum   = sum + exp_b;
            check($sformatf("%s_pl%0d", name, i), rx_q[start+2+i], exp_b);
        end
`ifdef FRAMER_CHECKSUM_EN
        check({name, "_cksum"}, rx_q[start+PB+2], sum);
`endif
        found = 0;
        foreach (done_q[j]) if (done_q[j] == start + FL) found = 1;
        check({name, "_done"}, found, 1);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst      = 1'b1;
        tx_ready = 1'b0;
        wr_ptr   = rd_ptr;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Cycle-exact vector table for the first frame
    // ------------------------------------------------------------------
    typedef struct {
        logic       tx_ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_rd;
        logic       exp_fr;
        logic       exp_done;
    } vec_t;

    vec_t vec [0:63];
    int   n_rows;

    initial begin
        int base;
        int k;
        int last;

        // Frame timeline with tx_ready high: IDLE, SYNC, SEQ, then
        // FETCH/WAIT/DATA per payload byte (payload byte k at cycle 5+3(k-1)).
        last = 3 * PB + 2;
`ifdef FRAMER_CHECKSUM_EN
        last = last + 1;
`endif
        n_rows = last + 2;
        for (int c = 0; c < n_rows; c++) begin
            vec[c] = '{tx_ready: 1'b1, exp_valid: 1'b0, exp_data: 8'h00,
                       exp_rd: 1'b0, exp_fr: 1'b0, exp_done: 1'b0};
            if (c == 0 || c == last + 1) vec[c].exp_fr = 1'b1;
            if (c == 1) begin vec[c].exp_valid = 1'b1; vec[c].exp_data = SYNC; end
            if (c == 2) begin vec[c].exp_valid = 1'b1; vec[c].exp_data = 8'h00; end
            if (c >= 3 && c < 3 * PB + 3) begin
                if ((c - 3) % 3 == 0) vec[c].exp_rd = 1'b1;
                if ((c - 3) % 3 == 2) begin
                    vec[c].exp_valid = 1'b1;
                    vec[c].exp_data  = 8'((c - 3) / 3 + 1);
`ifndef FRAMER_CHECKSUM_EN
                    if (c == last) vec[c].exp_done = 1'b1;
`endif
                end
            end
`ifdef FRAMER_CHECKSUM_EN
            if (c == last) begin
                vec[c].exp_valid = 1'b1;
                vec[c].exp_data  = 8'h88;  // 0x00 + sum(0x01..0x10) = 0x88
                vec[c].exp_done  = 1'b1;
            end
`endif
        end

        // ---- Reset with FIFO preloaded 0x01..0x10, then the vector run ----
        rst      = 1'b1;
        tx_ready = 1'b0;
        for (int i = 1; i <= PB; i++) push(8'(i));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int c = 0; c < n_rows; c++) begin
            tx_ready = vec[c].tx_ready;
            @(negedge clk);
            check($sformatf("vec%0d_valid", c), tx_valid, vec[c].exp_valid);
            if (vec[c].exp_valid)
                check($sformatf("vec%0d_data", c), tx_data, vec[c].exp_data);
            check($sformatf("vec%0d_rd_en", c), fifo_rd_en, vec[c].exp_rd);
            check($sformatf("vec%0d_frame_ready", c), frame_ready, vec[c].exp_fr);
            check($sformatf("vec%0d_frame_done", c), frame_done, vec[c].exp_done);
            @(posedge clk); #1;
        end
        compare_frame("first", 0, 8'h00, 8'h01, 8'h01);

        // ---- Backpressure at payload byte 3 ----
        do_reset(2);
        base = rx_q.size();
        for (int i = 1; i <= PB; i++) push(8'(i));
        tx_ready = 1'b1;
        wait_rx(base + 4, 100, "bp_reach");
        tx_ready = 1'b0;
        k = 0;
        while (!tx_valid && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check("bp_valid_seen", tx_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", i), tx_valid, 1);
            check($sformatf("bp_hold%0d_data", i), tx_data, 8'h03);
            check($sformatf("bp_hold%0d_rd_en", i), fifo_rd_en, 0);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_rx(base + FL, 200, "bp_finish");
        compare_frame("bp", base, 8'h00, 8'h01, 8'h01);

        // ---- Underrun after 4 payload bytes ----
        do_reset(2);
        base = rx_q.size();
        for (int i = 1; i <= 4; i++) push(8'(i));
        tx_ready = 1'b1;
        wait_rx(base + 6, 100, "ur_reach");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("ur%0d_valid", i), tx_valid, 0);
            check($sformatf("ur%0d_rd_en", i), fifo_rd_en, 0);
        end
        @(posedge clk); #1;
        for (int i = 5; i <= PB; i++) push(8'(i));
        wait_rx(base + FL, 200, "ur_finish");
        compare_frame("ur", base, 8'h00, 8'h01, 8'h01);

        // ---- Sequence wrap over 257 frames of zeros ----
        do_reset(2);
        base = rx_q.size();
        for (int i = 0; i < 257 * PB; i++) push(8'h00);
        tx_ready = 1'b1;
        wait_rx(base + 257 * FL, 257 * 60, "wrap_finish");
        for (int f = 0; f < 257; f++)
            compare_frame($sformatf("wrap%0d", f), base + f * FL, 8'(f), 8'h00, 8'h00);

        // ---- Reset in the middle of payload byte 7 ----
        do_reset(2);
        base = rx_q.size();
        for (int i = 1; i <= PB; i++) push(8'(i));
        tx_ready = 1'b1;
        wait_rx(base + 8, 100, "rst_reach");
        tx_ready = 1'b0;
        k = 0;
        while (!tx_valid && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check("rst_byte7", tx_data, 8'h07);
        rst    = 1'b1;
        wr_ptr = rd_ptr;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", tx_valid, 0);
        check("rst_frame_ready", frame_ready, 1);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_no_partial", rx_q.size(), base + 8);
        @(posedge clk); #1;
        base = rx_q.size();
        for (int i = 0; i < PB; i++) push(8'(8'h40 + i));
        tx_ready = 1'b1;
        wait_rx(base + FL, 200, "rst_next");
        compare_frame("after_rst", base, 8'h00, 8'h40, 8'h01);

        repeat (3) @(posedge clk);
        check("protocol_violations", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
